// File: rtl/apb_sram_ws_pkg.sv
// apb_sram_pkg: shared FSM state enum, wait counter width and byte-strobe merge helper for apb_sram_ws
package apb_sram_pkg;
  typedef enum logic {ST_IDLE, ST_ACCESS} state_e;
  localparam int WAIT_CNT_W = 4;
  function automatic logic [63:0] strb_merge(input logic [63:0] old_w, input logic [63:0] new_w, input logic [7:0] strb);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8+:8] = strb[i] ? new_w[i*8+:8] : old_w[i*8+:8];
    return r;
  endfunction
endpackage

// File: rtl/apb_sram_ws_if.sv
// apb_sram_ws_if: APB3/APB4 bus bundle (PSEL PENABLE PWRITE PADDR PWDATA PSTRB from master; PRDATA PREADY PSLVERR from slave)
interface apb_sram_ws_if #(parameter int ADDR_WIDTH = 8, parameter int DATA_WIDTH = 32);
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;
  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, input PRDATA, PREADY, PSLVERR);
  modport slave (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_sram_ws_sram_be_bank.sv
// sram_be_bank: DEPTH x DATA_WIDTH single-port RAM, sync read (re_i -> rdata_o next edge), byte-enable write (we_i, strb_i), no array reset
module sram_be_bank
  import apb_sram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 200
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic                    re_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] strb_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0] idx;
  assign idx = IW'(addr_i);
  always_ff @(posedge clk) begin
    if (we_i) mem[idx] <= DATA_WIDTH'(strb_merge(64'(mem[idx]), 64'(wdata_i), 8'(strb_i)));
    if (re_i) rdata_o <= mem[idx];
  end
endmodule

// File: rtl/apb_sram_ws.sv
// apb_sram_ws: APB slave over sram_be_bank with WAIT_STATES wait cycles and PSLVERR on addr>=DEPTH; ports PCLK, PRESET (sync high), bus (apb_sram_ws_if.slave), wp_limit only with APB_SRAM_WP_EN (write-protect words below wp_limit)
module apb_sram_ws
  import apb_sram_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 200,
  parameter int WAIT_STATES = 1
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
`ifdef APB_SRAM_WP_EN
  input  logic [ADDR_WIDTH-1:0] wp_limit,
`endif
  apb_sram_ws_if.slave          bus
);
  localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WS      = WAIT_CNT_W'(WAIT_STATES);
  localparam logic                  NO_WAIT = WAIT_STATES == 0;
  state_e                  st_q;
  logic [WAIT_CNT_W-1:0]   wait_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q, err_q, pready_q, pslverr_q;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    setup, in_range, err_d, re, we, last_wait;
  assign setup     = st_q == ST_IDLE && bus.PSEL && !bus.PENABLE;
  assign in_range  = {1'b0, bus.PADDR} < DEPTH_L;
`ifdef APB_SRAM_WP_EN
  assign err_d     = !in_range || (bus.PWRITE && bus.PADDR < wp_limit);
`else
  assign err_d     = !in_range;
`endif
  assign re        = setup && !bus.PWRITE && in_range && !PRESET;
  assign we        = st_q == ST_ACCESS && bus.PSEL && bus.PENABLE && pready_q && write_q && !err_q && !PRESET;
  assign last_wait = wait_q == WAIT_CNT_W'(1);
  sram_be_bank #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_bank (
    .clk     (PCLK),
    .we_i    (we),
    .re_i    (re),
    .addr_i  (st_q == ST_IDLE ? bus.PADDR : addr_q),
    .wdata_i (bus.PWDATA),
    .strb_i  (bus.PSTRB),
    .rdata_o (rdata)
  );
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      st_q      <= ST_IDLE;
      wait_q    <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else if (st_q == ST_IDLE) begin
      if (setup) begin
        st_q      <= ST_ACCESS;
        wait_q    <= WS;
        addr_q    <= bus.PADDR;
        write_q   <= bus.PWRITE;
        err_q     <= err_d;
        pready_q  <= NO_WAIT;
        pslverr_q <= NO_WAIT && err_d;
      end
    end else if (!bus.PSEL || (pready_q && bus.PENABLE)) begin
      st_q      <= ST_IDLE;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else if (!pready_q) begin
      wait_q    <= wait_q - WAIT_CNT_W'(1);
      pready_q  <= last_wait;
      pslverr_q <= last_wait && err_q;
    end
  end
  assign bus.PREADY  = pready_q;
  assign bus.PSLVERR = pslverr_q;
  assign bus.PRDATA  = (pready_q && !write_q && !err_q) ? rdata : '0;
endmodule

// File: tb/tb_apb_sram_ws.sv
// tb_apb_sram_ws: directed scoreboard bench driving a zero-wait and a three-wait apb_sram_ws instance
module tb_apb_sram_ws;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic        sel = 1'b0, psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
`ifdef APB_SRAM_WP_EN
  logic [7:0]  wp_limit = '0;
`endif
  int checks = 0, failures = 0;
  typedef struct {logic [31:0] rd; logic err;} exp_t;
  exp_t q[$];
  apb_sram_ws_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) b0 ();
  apb_sram_ws_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) b3 ();
  assign b0.PSEL = psel && !sel;
  assign b3.PSEL = psel && sel;
  assign b0.PENABLE = penable;
  assign b3.PENABLE = penable;
  assign b0.PWRITE = pwrite;
  assign b3.PWRITE = pwrite;
  assign b0.PADDR = paddr;
  assign b3.PADDR = paddr;
  assign b0.PWDATA = pwdata;
  assign b3.PWDATA = pwdata;
  assign b0.PSTRB = pstrb;
  assign b3.PSTRB = pstrb;
  apb_sram_ws #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(200), .WAIT_STATES(0)) u0 (
    .PCLK(clk), .PRESET(rst),
`ifdef APB_SRAM_WP_EN
    .wp_limit(wp_limit),
`endif
    .bus(b0));
  apb_sram_ws #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(200), .WAIT_STATES(3)) u3 (
    .PCLK(clk), .PRESET(rst),
`ifdef APB_SRAM_WP_EN
    .wp_limit(wp_limit),
`endif
    .bus(b3));
  wire        pready  = sel ? b3.PREADY : b0.PREADY;
  wire        pslverr = sel ? b3.PSLVERR : b0.PSLVERR;
  wire [31:0] prdata  = sel ? b3.PRDATA : b0.PRDATA;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic s, input logic w, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] st, input logic [31:0] er, input logic ee);
    int waits;
    exp_t e;
    q.push_back('{rd: er, err: ee});
    @(posedge clk) #1;
    sel = s; psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = st;
    @(posedge clk) #1;
    penable = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!pready && waits < 20) begin
      chk("wait_prdata", 64'(prdata), 64'(0));
      chk("wait_pslverr", 64'(pslverr), 64'(0));
      waits++;
      @(negedge clk);
    end
    e = q.pop_front();
    chk("wait_count", 64'(waits), s ? 64'(3) : 64'(0));
    chk("prdata", 64'(prdata), 64'(e.rd));
    chk("pslverr", 64'(pslverr), 64'(e.err));
    @(posedge clk) #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("ready_pulse", 64'(pready), 64'(0));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pready0", 64'(b0.PREADY), 64'(0));
    chk("rst_pslverr3", 64'(b3.PSLVERR), 64'(0));
    chk("rst_prdata0", 64'(b0.PRDATA), 64'(0));
    rst = 1'b0;
    // zero-wait: basic write/read, strobed merge, empty strobe, out-of-range
    xfer(0, 1, 8'd5, 32'hDEADBEEF, 4'hF, 32'h0, 0);
    xfer(0, 0, 8'd5, 32'h0, 4'h0, 32'hDEADBEEF, 0);
    xfer(0, 1, 8'd5, 32'h11223344, 4'h5, 32'h0, 0);
    xfer(0, 0, 8'd5, 32'h0, 4'h0, 32'hDE22BE44, 0);
    xfer(0, 1, 8'd5, 32'hFFFFFFFF, 4'h0, 32'h0, 0);
    xfer(0, 0, 8'd5, 32'h0, 4'h0, 32'hDE22BE44, 0);
    xfer(0, 1, 8'd199, 32'h0BADF00D, 4'hF, 32'h0, 0);
    xfer(0, 1, 8'd200, 32'h12345678, 4'hF, 32'h0, 1);
    xfer(0, 0, 8'd255, 32'h0, 4'h0, 32'h0, 1);
    xfer(0, 0, 8'd199, 32'h0, 4'h0, 32'h0BADF00D, 0);
    // three wait states
    xfer(1, 1, 8'd5, 32'hDEADBEEF, 4'hF, 32'h0, 0);
    xfer(1, 0, 8'd5, 32'h0, 4'h0, 32'hDEADBEEF, 0);
    xfer(1, 0, 8'd200, 32'h0, 4'h0, 32'h0, 1);
    // reset during a write wait cycle aborts the write
    xfer(1, 1, 8'd7, 32'hA5A5A5A5, 4'hF, 32'h0, 0);
    @(posedge clk) #1;
    sel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd7; pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge clk) #1;
    penable = 1'b1;
    @(posedge clk) #1;
    rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("abort_pready", 64'(b3.PREADY), 64'(0));
    chk("abort_pslverr", 64'(b3.PSLVERR), 64'(0));
    chk("abort_prdata", 64'(b3.PRDATA), 64'(0));
    xfer(1, 0, 8'd7, 32'h0, 4'h0, 32'hA5A5A5A5, 0);
`ifdef APB_SRAM_WP_EN
    xfer(0, 1, 8'd3, 32'h33333333, 4'hF, 32'h0, 0);
    wp_limit = 8'd16;
    xfer(0, 1, 8'd3, 32'hCCCCCCCC, 4'hF, 32'h0, 1);
    xfer(0, 0, 8'd3, 32'h0, 4'h0, 32'h33333333, 0);
    xfer(0, 1, 8'd16, 32'h16161616, 4'hF, 32'h0, 0);
    xfer(0, 0, 8'd16, 32'h0, 4'h0, 32'h16161616, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
